// File: rtl/tof_frame_writer_pkg.sv
// Shared types and constants for the ToF frame writer.
package tof_frame_pkg;

  // Writer FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Default configuration of the frame writer.
  localparam int DEF_N_CH       = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_FRAME_LEN  = 64;
  localparam int DEF_ADDR_W     = 6;
  localparam int DEF_WR_HOLD    = 2;
  localparam int DEF_CONTINUOUS = 0;

  // Width needed to hold an index in 0..n-1 (never narrower than one bit).
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tof_frame_writer_if.sv
// Sensor-side and BRAM-side signal bundle of the ToF frame writer.
interface tof_frame_writer_if #(
  parameter int N_CH   = 8,
  parameter int DATA_W = 16,
  parameter int ADDR_W = 6
);
  import tof_frame_pkg::*;

  localparam int IDX_W = idx_width(N_CH);

  logic [N_CH-1:0]        tof_dr;
  logic [N_CH*DATA_W-1:0] tof_data;
  logic                   clear;
  logic [N_CH-1:0]        tof_ack;
  logic                   mem_wea;
  logic [ADDR_W-1:0]      mem_addr;
  logic [DATA_W-1:0]      mem_din;
  logic [IDX_W-1:0]       tof_index;
  logic                   frame_done;
  logic                   all_data_written;

  // Environment side: sensors, frame control and the BRAM/solver observers.
  modport master (
    output tof_dr, tof_data, clear,
    input  tof_ack, mem_wea, mem_addr, mem_din, tof_index, frame_done, all_data_written
  );

  // Writer side.
  modport slave (
    input  tof_dr, tof_data, clear,
    output tof_ack, mem_wea, mem_addr, mem_din, tof_index, frame_done, all_data_written
  );

endinterface

// File: rtl/tof_frame_writer_rr_select.sv
// Combinational round-robin selector: first requester at or after ptr, wrapping.
module rr_select #(
  parameter int N_CH  = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_CH-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_idx
);

  localparam int SUM_W = IDX_W + 1;
  localparam logic [SUM_W-1:0] N_CH_C = SUM_W'(N_CH);

  logic [2*N_CH-1:0] req2_s;
  logic [2*N_CH-1:0] shifted_s;
  logic [N_CH-1:0]   rot_s;
  logic [IDX_W-1:0]  off_s;
  logic [SUM_W-1:0]  sum_s;

  // Rotate requests so ptr sits at bit 0, take the lowest set bit, then map back.
  always_comb begin
    req2_s    = {req, req};
    shifted_s = req2_s >> ptr;
    rot_s     = shifted_s[N_CH-1:0];
    off_s     = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      off_s = rot_s[i] ? IDX_W'(i) : off_s;
    end
    grant_valid = |rot_s;
    sum_s       = {1'b0, ptr} + {1'b0, off_s};
    if (sum_s >= N_CH_C) begin
      grant_idx = IDX_W'(sum_s - N_CH_C);
    end else begin
      grant_idx = IDX_W'(sum_s);
    end
  end

endmodule

// File: rtl/tof_frame_writer.sv
// ToF frame writer: round-robin capture of N ToF channels into a linear frame in BRAM.
module tof_frame_writer
  import tof_frame_pkg::*;
#(
  parameter int N_CH       = DEF_N_CH,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FRAME_LEN  = DEF_FRAME_LEN,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int WR_HOLD    = DEF_WR_HOLD,
  parameter int CONTINUOUS = DEF_CONTINUOUS
) (
  input  logic             clk,
  input  logic             reset_n,
  tof_frame_writer_if.slave bus
);

  localparam int IDX_W  = idx_width(N_CH);
  localparam int CNT_W  = $clog2(FRAME_LEN + 1);
  localparam int HOLD_W = idx_width(WR_HOLD);
  localparam bit CONT_MODE = (CONTINUOUS != 0);
  localparam logic [CNT_W-1:0]  FRAME_LEN_C  = CNT_W'(FRAME_LEN);
  localparam logic [HOLD_W-1:0] HOLD_LAST_C  = HOLD_W'(WR_HOLD - 1);
  localparam logic [IDX_W-1:0]  LAST_CH_C    = IDX_W'(N_CH - 1);
  localparam logic [N_CH-1:0]   ONE_HOT_BASE = {{(N_CH-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   wr_count_q, wr_count_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [N_CH-1:0]    tof_ack_q, tof_ack_d;
  logic               mem_wea_q, mem_wea_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]  mem_din_q, mem_din_d;
  logic [IDX_W-1:0]   tof_index_q, tof_index_d;
  logic               frame_done_q, frame_done_d;
  logic               adw_q, adw_d;

  logic               grant_valid_s;
  logic [IDX_W-1:0]   grant_idx_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic               last_hold_s;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               frame_full_s;

  rr_select #(
    .N_CH  (N_CH),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .req         (bus.tof_dr),
    .ptr         (rr_ptr_q),
    .grant_valid (grant_valid_s),
    .grant_idx   (grant_idx_s)
  );

  // Reading of the granted channel.
  always_comb begin
    sel_data_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      sel_data_s = (grant_idx_s == IDX_W'(k)) ? bus.tof_data[k*DATA_W +: DATA_W] : sel_data_s;
    end
  end

  // End-of-write and end-of-frame detection shared by next-state and output logic.
  always_comb begin
    last_hold_s  = (state_q == WRITE) && (hold_cnt_q == HOLD_LAST_C);
    cnt_inc_s    = wr_count_q + CNT_W'(1);
    frame_full_s = last_hold_s && (cnt_inc_s == FRAME_LEN_C);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: clear always wins and returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else if (grant_valid_s) begin
          state_d = WRITE;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else if (frame_full_s && !CONT_MODE) begin
          state_d = DONE;
        end else if (last_hold_s) begin
          state_d = IDLE;
        end else begin
          state_d = WRITE;
        end
      end
      DONE: begin
        if (bus.clear) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath next values; every visible output is registered.
  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    wr_count_d   = wr_count_q;
    hold_cnt_d   = hold_cnt_q;
    tof_ack_d    = '0;
    mem_wea_d    = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_din_d    = mem_din_q;
    tof_index_d  = tof_index_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.clear) begin
          wr_count_d = '0;
          hold_cnt_d = '0;
        end else if (grant_valid_s) begin
          tof_ack_d   = ONE_HOT_BASE << grant_idx_s;
          mem_wea_d   = 1'b1;
          mem_addr_d  = ADDR_W'(wr_count_q);
          mem_din_d   = sel_data_s;
          tof_index_d = grant_idx_s;
          hold_cnt_d  = '0;
          if (grant_idx_s == LAST_CH_C) begin
            rr_ptr_d = '0;
          end else begin
            rr_ptr_d = grant_idx_s + IDX_W'(1);
          end
        end else begin
          hold_cnt_d = '0;
        end
      end
      WRITE: begin
        if (bus.clear) begin
          // Abort: the in-progress write is truncated and the frame restarts.
          wr_count_d = '0;
          hold_cnt_d = '0;
        end else if (last_hold_s) begin
          hold_cnt_d   = '0;
          frame_done_d = frame_full_s;
          if (frame_full_s && CONT_MODE) begin
            wr_count_d = '0;
          end else begin
            wr_count_d = cnt_inc_s;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
          mem_wea_d  = 1'b1;
        end
      end
      DONE: begin
        if (bus.clear) begin
          wr_count_d = '0;
        end else begin
          wr_count_d = wr_count_q;
        end
      end
      default: begin
        wr_count_d = '0;
        hold_cnt_d = '0;
      end
    endcase
    adw_d = CONT_MODE ? frame_done_d : (state_d == DONE);
  end

  // Datapath and output registers; async reset clears every output at once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr_q     <= '0;
      wr_count_q   <= '0;
      hold_cnt_q   <= '0;
      tof_ack_q    <= '0;
      mem_wea_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_din_q    <= '0;
      tof_index_q  <= '0;
      frame_done_q <= 1'b0;
      adw_q        <= 1'b0;
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      wr_count_q   <= wr_count_d;
      hold_cnt_q   <= hold_cnt_d;
      tof_ack_q    <= tof_ack_d;
      mem_wea_q    <= mem_wea_d;
      mem_addr_q   <= mem_addr_d;
      mem_din_q    <= mem_din_d;
      tof_index_q  <= tof_index_d;
      frame_done_q <= frame_done_d;
      adw_q        <= adw_d;
    end
  end

  assign bus.tof_ack          = tof_ack_q;
  assign bus.mem_wea          = mem_wea_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.mem_din          = mem_din_q;
  assign bus.tof_index        = tof_index_q;
  assign bus.frame_done       = frame_done_q;
  assign bus.all_data_written = adw_q;

endmodule

// File: tb/tb_tof_frame_writer.sv
// Scoreboard bench: DUT A single-shot 64-write frame, DUT B continuous 4-write frame.
module tb_tof_frame_writer;

  typedef struct {
    logic [7:0]  ack;
    logic [15:0] din;
    int          addr;
    int          idx;
    int          hold;
    int          gap;
  } exp_rec_t;

  logic clk = 1'b0;
  logic reset_n_a, reset_n_b;
  int checks = 0;
  int failures = 0;

  exp_rec_t exp_a[$];
  exp_rec_t exp_b[$];
  exp_rec_t rec_a, rec_b;
  logic [15:0] dat_a [8];
  logic [15:0] dat_b [8];

  int cyc_a = 0, last_ack_a = 0, run_a = 0, hold_a = 0, fd_cnt_a = 0;
  int cyc_b = 0, last_ack_b = 0, run_b = 0, hold_b = 0, fd_cnt_b = 0, acks_b = 0;

  tof_frame_writer_if #(.N_CH(8), .DATA_W(16), .ADDR_W(6)) ifa ();
  tof_frame_writer_if #(.N_CH(8), .DATA_W(16), .ADDR_W(2)) ifb ();

  tof_frame_writer #(
    .N_CH(8), .DATA_W(16), .FRAME_LEN(64), .ADDR_W(6), .WR_HOLD(2), .CONTINUOUS(0)
  ) dut_a (
    .clk(clk), .reset_n(reset_n_a), .bus(ifa)
  );

  tof_frame_writer #(
    .N_CH(8), .DATA_W(16), .FRAME_LEN(4), .ADDR_W(2), .WR_HOLD(2), .CONTINUOUS(1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n_b), .bus(ifb)
  );

  always #5 clk = ~clk;

  // Pack per-channel sensor readings onto the data buses.
  always_comb begin
    ifa.tof_data = '0;
    ifb.tof_data = '0;
    for (int k = 0; k < 8; k++) begin
      ifa.tof_data[k*16 +: 16] = dat_a[k];
      ifb.tof_data[k*16 +: 16] = dat_b[k];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic exp_rec_t mk(input int ch, input logic [15:0] d, input int addr,
                                  input int hold, input int gap);
    exp_rec_t r;
    logic [7:0] one;
    one    = 8'h01;
    r.ack  = one << ch;
    r.din  = d;
    r.addr = addr;
    r.idx  = ch;
    r.hold = hold;
    r.gap  = gap;
    return r;
  endfunction

  // Monitor A: pop one expectation per ack, check write fields, spacing and wea hold length.
  always @(negedge clk) begin
    cyc_a++;
    if (ifa.frame_done) fd_cnt_a++;
    if (ifa.tof_ack != 8'h00) begin
      if (exp_a.size() == 0) begin
        chk("A_unexpected_ack", 32'(ifa.tof_ack), 32'h0);
      end else begin
        rec_a = exp_a.pop_front();
        chk("A_ack", 32'(ifa.tof_ack), 32'(rec_a.ack));
        chk("A_addr", 32'(ifa.mem_addr), 32'(rec_a.addr));
        chk("A_din", 32'(ifa.mem_din), 32'(rec_a.din));
        chk("A_idx", 32'(ifa.tof_index), 32'(rec_a.idx));
        chk("A_wea_with_ack", 32'(ifa.mem_wea), 32'h1);
        if (rec_a.gap != 0) chk("A_gap", 32'(cyc_a - last_ack_a), 32'(rec_a.gap));
        hold_a = rec_a.hold;
      end
      last_ack_a = cyc_a;
    end
    if (ifa.mem_wea) begin
      run_a++;
    end else if (run_a != 0) begin
      chk("A_hold", 32'(run_a), 32'(hold_a));
      run_a = 0;
    end
  end

  // Monitor B: same scoreboard plus continuous-mode frame_done placement.
  always @(negedge clk) begin
    cyc_b++;
    if (ifb.frame_done) begin
      fd_cnt_b++;
      chk("B_fd_after_acks", 32'(acks_b), 32'(fd_cnt_b * 4));
    end
    if (ifb.frame_done || ifb.all_data_written)
      chk("B_adw_eq_fd", 32'(ifb.all_data_written), 32'(ifb.frame_done));
    if (ifb.tof_ack != 8'h00) begin
      acks_b++;
      if (exp_b.size() == 0) begin
        chk("B_unexpected_ack", 32'(ifb.tof_ack), 32'h0);
      end else begin
        rec_b = exp_b.pop_front();
        chk("B_ack", 32'(ifb.tof_ack), 32'(rec_b.ack));
        chk("B_addr", 32'(ifb.mem_addr), 32'(rec_b.addr));
        chk("B_din", 32'(ifb.mem_din), 32'(rec_b.din));
        chk("B_idx", 32'(ifb.tof_index), 32'(rec_b.idx));
        if (rec_b.gap != 0) chk("B_gap", 32'(cyc_b - last_ack_b), 32'(rec_b.gap));
        hold_b = rec_b.hold;
      end
      last_ack_b = cyc_b;
    end
    if (ifb.mem_wea) begin
      run_b++;
    end else if (run_b != 0) begin
      chk("B_hold", 32'(run_b), 32'(hold_b));
      run_b = 0;
    end
  end

  task automatic wait_ack_a(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ifa.tof_ack == 8'h00 && n < 40);
    if (ifa.tof_ack == 8'h00) begin
      checks++;
      failures++;
      $display("FAIL %s ack timeout actual=none expected=ack", tag);
    end
  endtask

  task automatic wait_ack_b(input string tag);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (ifb.tof_ack == 8'h00 && n < 40);
    if (ifb.tof_ack == 8'h00) begin
      checks++;
      failures++;
      $display("FAIL %s ack timeout actual=none expected=ack", tag);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_ack"}, 32'(ifa.tof_ack), 32'h0);
    chk({tag, "_wea"}, 32'(ifa.mem_wea), 32'h0);
    chk({tag, "_addr"}, 32'(ifa.mem_addr), 32'h0);
    chk({tag, "_din"}, 32'(ifa.mem_din), 32'h0);
    chk({tag, "_idx"}, 32'(ifa.tof_index), 32'h0);
    chk({tag, "_fd"}, 32'(ifa.frame_done), 32'h0);
    chk({tag, "_adw"}, 32'(ifa.all_data_written), 32'h0);
  endtask

  initial begin
    reset_n_a = 1'b0;
    reset_n_b = 1'b0;
    ifa.tof_dr = 8'h00;
    ifa.clear  = 1'b0;
    ifb.tof_dr = 8'h00;
    ifb.clear  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      dat_a[k] = 16'h0000;
      dat_b[k] = 16'h2000 + 16'(k);
    end
    #12;
    chk_zero_a("A_reset");
    chk("B_reset_wea", 32'(ifb.mem_wea), 32'h0);
    chk("B_reset_adw", 32'(ifb.all_data_written), 32'h0);
    @(posedge clk); #1;
    reset_n_a = 1'b1;
    reset_n_b = 1'b1;

    // Single channel capture on channel 2.
    dat_a[2] = 16'hA5A5;
    exp_a.push_back(mk(2, 16'hA5A5, 0, 2, 0));
    ifa.tof_dr = 8'h04;
    wait_ack_a("A_single");
    ifa.tof_dr = 8'h00;
    repeat (3) begin @(posedge clk); #1; end

    // Restart from a clean reset, then a full frame with all channels ready.
    reset_n_a = 1'b0;
    @(posedge clk); #1;
    reset_n_a = 1'b1;
    for (int k = 0; k < 8; k++) dat_a[k] = 16'h1000 + 16'(k) * 16'h0111;
    for (int i = 0; i < 64; i++)
      exp_a.push_back(mk(i % 8, 16'h1000 + 16'(i % 8) * 16'h0111, i, 2, (i == 0) ? 0 : 3));
    ifa.tof_dr = 8'hFF;
    for (int i = 0; i < 64; i++) wait_ack_a("A_frame");
    repeat (12) begin @(posedge clk); #1; end
    chk("A_fd_count_frame", 32'(fd_cnt_a), 32'h1);
    chk("A_adw_level", 32'(ifa.all_data_written), 32'h1);
    chk("A_done_wea", 32'(ifa.mem_wea), 32'h0);

    // Clear from DONE; next write lands at address 0.
    ifa.tof_dr = 8'h00;
    ifa.clear = 1'b1;
    @(posedge clk); #1;
    ifa.clear = 1'b0;
    chk("A_adw_after_clear", 32'(ifa.all_data_written), 32'h0);
    exp_a.push_back(mk(5, dat_a[5], 0, 2, 0));
    ifa.tof_dr = 8'h20;
    wait_ack_a("A_after_clear");
    for (int a = 1; a <= 4; a++) begin
      exp_a.push_back(mk(a, dat_a[a], a, 2, 0));
      ifa.tof_dr = 8'h01 << a;
      wait_ack_a("A_fill");
    end

    // Clear in the first WRITE cycle of address 5 truncates that write.
    exp_a.push_back(mk(6, dat_a[6], 5, 1, 0));
    ifa.tof_dr = 8'h40;
    wait_ack_a("A_abort");
    ifa.clear = 1'b1;
    ifa.tof_dr = 8'h00;
    @(posedge clk); #1;
    ifa.clear = 1'b0;
    chk("A_wea_after_abort", 32'(ifa.mem_wea), 32'h0);
    exp_a.push_back(mk(4, dat_a[4], 0, 2, 0));
    ifa.tof_dr = 8'h10;
    wait_ack_a("A_after_abort");

    // Async reset between clock edges in the middle of a write.
    dat_a[3] = 16'hBEEF;
    exp_a.push_back(mk(3, 16'hBEEF, 1, 1, 0));
    ifa.tof_dr = 8'h08;
    wait_ack_a("A_pre_reset");
    ifa.tof_dr = 8'h00;
    @(negedge clk); #2;
    reset_n_a = 1'b0;
    #1;
    chk_zero_a("A_async");
    @(posedge clk); #1;
    reset_n_a = 1'b1;
    dat_a[0] = 16'h0C0C;
    dat_a[7] = 16'h7C7C;
    exp_a.push_back(mk(0, 16'h0C0C, 0, 2, 0));
    ifa.tof_dr = 8'h81;
    wait_ack_a("A_post_reset");
    ifa.tof_dr = 8'h00;
    repeat (6) begin @(posedge clk); #1; end
    chk("A_fd_count_final", 32'(fd_cnt_a), 32'h1);

    // Continuous mode: nine writes wrap addresses every four.
    for (int i = 0; i < 9; i++)
      exp_b.push_back(mk(i % 8, 16'h2000 + 16'(i % 8), i % 4, 2, (i == 0) ? 0 : 3));
    ifb.tof_dr = 8'hFF;
    for (int i = 0; i < 9; i++) wait_ack_b("B_wrap");
    ifb.tof_dr = 8'h00;
    repeat (8) begin @(posedge clk); #1; end
    chk("B_fd_count", 32'(fd_cnt_b), 32'h2);
    chk("B_adw_idle", 32'(ifb.all_data_written), 32'h0);

    chk("A_queue_empty", 32'(exp_a.size()), 32'h0);
    chk("B_queue_empty", 32'(exp_b.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
